// File: rtl/kfpc_bus_pkg.sv
// Shared types for the KFPC-XT 8088-side bus logic: processor status codes,
// bus controller FSM states and small status classification helpers.
package kfpc_bus_pkg;

  typedef enum logic [2:0] {
    INTA    = 3'b000,
    IOR     = 3'b001,
    IOW     = 3'b010,
    HALT    = 3'b011,
    CODE    = 3'b100,
    MEMR    = 3'b101,
    MEMW    = 3'b110,
    PASSIVE = 3'b111
  } bus_status_t;

  typedef enum logic [2:0] {
    ARMED_WAIT = 3'd0,
    IDLE       = 3'd1,
    T1         = 3'd2,
    T2         = 3'd3,
    T3         = 3'd4,
    TW         = 3'd5,
    T4         = 3'd6
  } bus_state_t;

  // Cycles in which the data transceiver points towards the processor.
  function automatic logic is_receive_cycle(input bus_status_t s);
    return (s == INTA) || (s == IOR) || (s == CODE) || (s == MEMR);
  endfunction

  // Memory read strobe covers both opcode fetch and data read.
  function automatic logic is_mem_read(input bus_status_t s);
    return (s == CODE) || (s == MEMR);
  endfunction

endpackage

// File: rtl/bus_command_generator.sv
// 8288-style bus controller: turns 8088 status into ALE, transceiver controls
// and active-low command strobes, walking T1/T2/T3/Tw/T4 with a wait timeout.
module bus_command_generator
  import kfpc_bus_pkg::*;
#(
  parameter int WRITE_ADVANCE  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] processor_status,
  input  logic       processor_ready,
  input  logic       address_enable_n,
  output logic       address_latch_enable,
  output logic       processor_transmit_or_receive_n,
  output logic       data_enable,
  output logic       memory_read_n,
  output logic       memory_write_n,
  output logic       io_read_n,
  output logic       io_write_n,
  output logic       interrupt_acknowledge_n,
  output logic       bus_cycle_busy,
  output logic       timeout_error
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam logic       TIMEOUT_ON    = (TIMEOUT_CYCLES != 0);
  localparam logic       WRITE_EARLY   = (WRITE_ADVANCE != 0);

  bus_state_t  state, next_state;
  bus_status_t cyc_status, next_cyc_status;
  bus_status_t live_status;
  logic [7:0]  wait_count, next_wait_count;
  logic        timeout_hit;

  logic next_busy, next_cmd_window, next_write_window;
  logic ale_d, dtr_n_d, den_d, mrd_n_d, mwr_n_d, ior_n_d, iow_n_d, inta_n_d, toerr_d;
  logic ale_q, dtr_n_q, den_q, mrd_n_q, mwr_n_q, ior_n_q, iow_n_q, inta_n_q, busy_q, toerr_q;

  assign live_status = bus_status_t'(processor_status);

  // Next-state logic: status is only looked at from IDLE and T4.
  always_comb begin
    next_state      = state;
    next_cyc_status = cyc_status;
    next_wait_count = wait_count;
    timeout_hit     = 1'b0;
    case (state)
      ARMED_WAIT: begin
        if (live_status == PASSIVE) next_state = IDLE;
      end
      IDLE: begin
        if (live_status != PASSIVE) begin
          next_state      = T1;
          next_cyc_status = live_status;
        end
      end
      T1: next_state = T2;
      T2: next_state = T3;
      T3: next_state = processor_ready ? T4 : TW;
      TW: begin
        if (TIMEOUT_ON && (wait_count == TIMEOUT_LIMIT)) begin
          next_state  = T4;
          timeout_hit = 1'b1;
        end else if (processor_ready) begin
          next_state = T4;
        end
      end
      T4: begin
        if (live_status != PASSIVE) begin
          next_state      = T1;
          next_cyc_status = live_status;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = ARMED_WAIT;
    endcase
    // The counter holds the number of Tw states entered so far in this cycle.
    if (next_state == T1) next_wait_count = 8'd0;
    else if (next_state == TW) next_wait_count = wait_count + 8'd1;
  end

  // Output decode one clock ahead so every strobe leaves a flop.
  always_comb begin
    next_busy         = (next_state == T1) || (next_state == T2) || (next_state == T3) ||
                        (next_state == TW) || (next_state == T4);
    next_cmd_window   = (next_state == T2) || (next_state == T3) || (next_state == TW);
    next_write_window = (next_state == T3) || (next_state == TW) ||
                        (WRITE_EARLY && (next_state == T2));
    ale_d    = (next_state == T1);
    dtr_n_d  = !(next_busy && is_receive_cycle(next_cyc_status));
    den_d    = next_cmd_window && (next_cyc_status != HALT);
    mrd_n_d  = !(next_cmd_window && is_mem_read(next_cyc_status));
    ior_n_d  = !(next_cmd_window && (next_cyc_status == IOR));
    inta_n_d = !(next_cmd_window && (next_cyc_status == INTA));
    mwr_n_d  = !(next_write_window && (next_cyc_status == MEMW));
    iow_n_d  = !(next_write_window && (next_cyc_status == IOW));
    toerr_d  = timeout_hit;
  end

  // State, cycle status, wait counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARMED_WAIT;
      cyc_status <= PASSIVE;
      wait_count <= 8'd0;
      ale_q      <= 1'b0;
      dtr_n_q    <= 1'b1;
      den_q      <= 1'b0;
      mrd_n_q    <= 1'b1;
      mwr_n_q    <= 1'b1;
      ior_n_q    <= 1'b1;
      iow_n_q    <= 1'b1;
      inta_n_q   <= 1'b1;
      busy_q     <= 1'b0;
      toerr_q    <= 1'b0;
    end else begin
      state      <= next_state;
      cyc_status <= next_cyc_status;
      wait_count <= next_wait_count;
      ale_q      <= ale_d;
      dtr_n_q    <= dtr_n_d;
      den_q      <= den_d;
      mrd_n_q    <= mrd_n_d;
      mwr_n_q    <= mwr_n_d;
      ior_n_q    <= ior_n_d;
      iow_n_q    <= iow_n_d;
      inta_n_q   <= inta_n_d;
      busy_q     <= next_busy;
      toerr_q    <= toerr_d;
    end
  end

  // DMA ownership masks the commands without disturbing the cycle timing.
  assign memory_read_n           = mrd_n_q  | ~address_enable_n;
  assign memory_write_n          = mwr_n_q  | ~address_enable_n;
  assign io_read_n               = ior_n_q  | ~address_enable_n;
  assign io_write_n              = iow_n_q  | ~address_enable_n;
  assign interrupt_acknowledge_n = inta_n_q | ~address_enable_n;

  assign address_latch_enable            = ale_q;
  assign processor_transmit_or_receive_n = dtr_n_q;
  assign data_enable                     = den_q;
  assign bus_cycle_busy                  = busy_q;
  assign timeout_error                   = toerr_q;

endmodule

// File: tb/tb_bus_command_generator.sv
// Bench for bus_command_generator: two instances (write-advance with a short
// timeout, normal write with timeout disabled) checked against a cycle model.
module tb_bus_command_generator;

  localparam int WA_A = 1;
  localparam int TO_A = 4;
  localparam int WA_B = 0;
  localparam int TO_B = 0;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] processor_status;
  logic       processor_ready;
  logic       address_enable_n;

  logic a_ale, a_dtr, a_den, a_mrd, a_mwr, a_ior, a_iow, a_inta, a_busy, a_toerr;
  logic b_ale, b_dtr, b_den, b_mrd, b_mwr, b_ior, b_iow, b_inta, b_busy, b_toerr;
  logic [9:0] act_a, act_b;

  always #5 clock = ~clock;

  bus_command_generator #(.WRITE_ADVANCE(WA_A), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clock(clock), .reset(reset), .processor_status(processor_status),
    .processor_ready(processor_ready), .address_enable_n(address_enable_n),
    .address_latch_enable(a_ale), .processor_transmit_or_receive_n(a_dtr),
    .data_enable(a_den), .memory_read_n(a_mrd), .memory_write_n(a_mwr),
    .io_read_n(a_ior), .io_write_n(a_iow), .interrupt_acknowledge_n(a_inta),
    .bus_cycle_busy(a_busy), .timeout_error(a_toerr)
  );

  bus_command_generator #(.WRITE_ADVANCE(WA_B), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clock(clock), .reset(reset), .processor_status(processor_status),
    .processor_ready(processor_ready), .address_enable_n(address_enable_n),
    .address_latch_enable(b_ale), .processor_transmit_or_receive_n(b_dtr),
    .data_enable(b_den), .memory_read_n(b_mrd), .memory_write_n(b_mwr),
    .io_read_n(b_ior), .io_write_n(b_iow), .interrupt_acknowledge_n(b_inta),
    .bus_cycle_busy(b_busy), .timeout_error(b_toerr)
  );

  assign act_a = {a_ale, a_dtr, a_den, a_mrd, a_mwr, a_ior, a_iow, a_inta, a_busy, a_toerr};
  assign act_b = {b_ale, b_dtr, b_den, b_mrd, b_mwr, b_ior, b_iow, b_inta, b_busy, b_toerr};

  localparam logic [9:0] RESET_VEC = 10'b0101111100;

  int compared   = 0;
  int mismatched = 0;
  string tag = "";

  // Cycle model: per instance, whether armed, whether a bus cycle is running,
  // clocks elapsed since its T1, whether it has reached its final clock.
  int wa_p [2] = '{WA_A, WA_B};
  int to_p [2] = '{TO_A, TO_B};
  bit m_armed [2];
  bit m_active[2];
  bit m_end   [2];
  bit m_to    [2];
  int m_idx   [2];
  int m_kind  [2];

  int cnt_ale_a, cnt_iow_a, cnt_iow_b, cnt_ior_a, cnt_to_a, cnt_to_b, step_no;
  int first_ale, last_ale;

  task automatic check_vec(input string name, input logic [9:0] act, input logic [9:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %b required %b (ale dtr_n den mrd_n mwr_n ior_n iow_n inta_n busy toerr)",
               name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input int st, input bit rdy);
    for (int k = 0; k < 2; k++) begin
      m_to[k] = 1'b0;
      if (rst) begin
        m_armed[k] = 0; m_active[k] = 0; m_end[k] = 0; m_idx[k] = 0;
      end else if (!m_active[k]) begin
        if (!m_armed[k]) m_armed[k] = (st == 7);
        else if (st != 7) begin
          m_active[k] = 1; m_idx[k] = 0; m_end[k] = 0; m_kind[k] = st;
        end
      end else if (m_end[k]) begin
        if (st != 7) begin
          m_idx[k] = 0; m_end[k] = 0; m_kind[k] = st;
        end else m_active[k] = 0;
      end else if (m_idx[k] < 2) begin
        m_idx[k]++;
      end else if (m_idx[k] >= 3 && to_p[k] != 0 && (m_idx[k] - 2) == to_p[k]) begin
        m_end[k] = 1; m_to[k] = 1;
      end else if (rdy) begin
        m_end[k] = 1;
      end else begin
        m_idx[k]++;
      end
    end
  endtask

  function automatic logic [9:0] model_out(input int k, input bit aen_n);
    bit ale, dtr_n, den, cmdw, wrw, mrd_n, mwr_n, ior_n, iow_n, inta_n;
    int kd;
    kd     = m_kind[k];
    ale    = m_active[k] && !m_end[k] && m_idx[k] == 0;
    dtr_n  = !(m_active[k] && (kd == 0 || kd == 1 || kd == 4 || kd == 5));
    cmdw   = m_active[k] && !m_end[k] && m_idx[k] >= 1;
    wrw    = m_active[k] && !m_end[k] && (m_idx[k] >= 2 || (wa_p[k] != 0 && m_idx[k] == 1));
    den    = cmdw && kd != 3;
    mrd_n  = !(cmdw && (kd == 4 || kd == 5)) || !aen_n;
    ior_n  = !(cmdw && kd == 1) || !aen_n;
    inta_n = !(cmdw && kd == 0) || !aen_n;
    mwr_n  = !(wrw && kd == 6) || !aen_n;
    iow_n  = !(wrw && kd == 2) || !aen_n;
    return {ale, dtr_n, den, mrd_n, mwr_n, ior_n, iow_n, inta_n, m_active[k], m_to[k]};
  endfunction

  task automatic step(input bit rst, input int st, input bit rdy, input bit aen);
    reset            = rst;
    processor_status = 3'(st);
    processor_ready  = rdy;
    address_enable_n = aen;
    @(posedge clock);
    model_step(rst, st, rdy);
    #1;
    step_no++;
    check_vec({tag, " dut_a"}, act_a, model_out(0, aen));
    check_vec({tag, " dut_b"}, act_b, model_out(1, aen));
    if (a_ale) begin
      cnt_ale_a++;
      if (first_ale < 0) first_ale = step_no;
      last_ale = step_no;
    end
    if (!a_iow)  cnt_iow_a++;
    if (!b_iow)  cnt_iow_b++;
    if (!a_ior)  cnt_ior_a++;
    if (a_toerr) cnt_to_a++;
    if (b_toerr) cnt_to_b++;
  endtask

  task automatic clear_counts();
    cnt_ale_a = 0; cnt_iow_a = 0; cnt_iow_b = 0; cnt_ior_a = 0;
    cnt_to_a = 0; cnt_to_b = 0; first_ale = -1; last_ale = -1;
  endtask

  typedef struct {
    bit       rst;
    bit [2:0] st;
    bit       rdy;
    bit       ale;
    bit       dtr_n;
    bit       den;
    bit       mrd_n;
    bit       busy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // rst st rdy | ale dtr_n den mrd_n busy  (outputs after the clock)
    vecs[0] = '{1, 3'b111, 1, 0, 1, 0, 1, 0};  // reset
    vecs[1] = '{0, 3'b111, 1, 0, 1, 0, 1, 0};  // armed -> idle
    vecs[2] = '{0, 3'b111, 1, 0, 1, 0, 1, 0};  // idle
    vecs[3] = '{0, 3'b101, 1, 1, 0, 0, 1, 1};  // T1
    vecs[4] = '{0, 3'b111, 1, 0, 0, 1, 0, 1};  // T2
    vecs[5] = '{0, 3'b111, 1, 0, 0, 1, 0, 1};  // T3
    vecs[6] = '{0, 3'b111, 1, 0, 0, 0, 1, 1};  // T4 (ready seen in T3)
    vecs[7] = '{0, 3'b111, 1, 0, 1, 0, 1, 0};  // idle

    reset = 1'b1; processor_status = 3'b111; processor_ready = 1'b1; address_enable_n = 1'b1;
    step_no = 0;
    clear_counts();
    #2;

    // MEMR read cycle from the vector table.
    tag = "memr_tbl";
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rst, int'(vecs[i].st), vecs[i].rdy, 1'b1);
      check_vec($sformatf("memr_tbl[%0d]", i), {5'b0, a_ale, a_dtr, a_den, a_mrd, a_busy},
                {5'b0, vecs[i].ale, vecs[i].dtr_n, vecs[i].den, vecs[i].mrd_n, vecs[i].busy});
    end

    // IOW with three wait states.
    tag = "iow_wait"; clear_counts();
    step(0, 2, 0, 1); step(0, 7, 0, 1); step(0, 7, 0, 1);
    step(0, 7, 0, 1); step(0, 7, 0, 1); step(0, 7, 0, 1);
    step(0, 7, 1, 1); step(0, 7, 1, 1);
    check_int("iow_low_clocks_advance", cnt_iow_a, 5);
    check_int("iow_low_clocks_normal", cnt_iow_b, 4);

    // MEMW back-to-back, no passive in between.
    tag = "memw_b2b"; clear_counts();
    for (int i = 0; i < 8; i++) step(0, 6, 1, 1);
    step(0, 7, 1, 1);
    check_int("b2b_ale_count", cnt_ale_a, 2);
    check_int("b2b_ale_spacing", last_ale - first_ale, 4);

    // INTA with DMA owning the bus during T2 only.
    tag = "inta_aen";
    step(0, 0, 1, 1);
    step(0, 7, 1, 0);
    check_int("inta_masked_t2", int'(a_inta), 1);
    step(0, 7, 1, 1);
    check_int("inta_low_t3", int'(a_inta), 0);
    step(0, 7, 1, 1); step(0, 7, 1, 1);

    // IOR with ready stuck low: timeout on dut_a, endless wait on dut_b.
    tag = "ior_timeout"; clear_counts();
    step(0, 1, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 7, 0, 1);
    step(0, 7, 0, 1);
    check_int("timeout_pulse_in_t4", int'(a_toerr), 1);
    check_int("ior_high_in_t4", int'(a_ior), 1);
    step(0, 7, 0, 1); step(0, 7, 0, 1);
    step(0, 7, 1, 1); step(0, 7, 1, 1);
    check_int("timeout_pulse_count", cnt_to_a, 1);
    check_int("ior_low_clocks_timeout", cnt_ior_a, 6);
    check_int("no_timeout_when_disabled", cnt_to_b, 0);

    // Stale status across reset release, then reset in a wait state.
    tag = "stale_rst"; clear_counts();
    step(1, 5, 1, 1); step(1, 5, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 5, 1, 1);
    check_int("no_ale_before_passive", cnt_ale_a, 0);
    step(0, 7, 1, 1);
    step(0, 5, 0, 1);
    check_int("ale_after_passive", int'(a_ale), 1);
    step(0, 7, 0, 1); step(0, 7, 0, 1); step(0, 7, 0, 1);
    step(1, 7, 0, 1);
    check_vec("reset_in_tw_a", act_a, RESET_VEC);
    check_vec("reset_in_tw_b", act_b, RESET_VEC);
    step(0, 7, 1, 1);

    // Randomised traffic against the model.
    tag = "random";
    for (int i = 0; i < 3000; i++) begin
      bit r;
      int s;
      r = ($urandom_range(199) == 0);
      s = ($urandom_range(1) == 0) ? 7 : int'($urandom_range(7));
      step(r, s, ($urandom_range(2) != 0), ($urandom_range(7) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
